// File: rtl/neuraedge_pe_driver.sv
// neuraedge_pe_driver
//   Sequences one dot product through an external MAC processing element.
//   A command carries the number of operand pairs; the driver clears the PE,
//   streams the accepted operand pairs into it, waits two cycles for the PE
//   pipeline to settle, captures the PE accumulator and presents it as the
//   result until it is consumed.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_len   command handshake, cmd_len = number of pairs
//   op_valid/op_ready/op_data/op_weight
//                                 operand-pair handshake (signed operands)
//   pe_enable, mac_clear, accumulate_en
//                                 PE control, decoded from the state register
//   pe_data, pe_weight, pe_data_valid
//                                 registered operands to the PE
//   pe_accum_in                   PE accumulator value
//   res_valid/res_ready/res_data  result handshake
//   busy                          high whenever the driver is not idle
module neuraedge_pe_driver #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ACCUM_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [DATA_WIDTH-1:0]   op_data,
  input  logic [WEIGHT_WIDTH-1:0] op_weight,
  output logic                    pe_enable,
  output logic                    mac_clear,
  output logic                    accumulate_en,
  output logic [DATA_WIDTH-1:0]   pe_data,
  output logic [WEIGHT_WIDTH-1:0] pe_weight,
  output logic                    pe_data_valid,
  input  logic [ACCUM_WIDTH-1:0]  pe_accum_in,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ACCUM_WIDTH-1:0]  res_data,
  output logic                    busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_RESULT
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 drain_second;

  // Handshake-facing controls depend on the state register only, so the
  // driver never forms a combinational path from an input to a ready.
  always_comb begin
    cmd_ready     = 1'b0;
    op_ready      = 1'b0;
    mac_clear     = 1'b0;
    pe_enable     = 1'b0;
    accumulate_en = 1'b0;
    res_valid     = 1'b0;
    busy          = 1'b1;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_CLEAR: begin
        mac_clear = 1'b1;
        pe_enable = 1'b1;
      end
      S_STREAM: begin
        op_ready      = 1'b1;
        pe_enable     = 1'b1;
        accumulate_en = 1'b1;
      end
      S_DRAIN: begin
        pe_enable     = 1'b1;
        accumulate_en = 1'b1;
      end
      S_RESULT: begin
        res_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      remaining     <= '0;
      drain_second  <= 1'b0;
      pe_data       <= '0;
      pe_weight     <= '0;
      pe_data_valid <= 1'b0;
      res_data      <= '0;
    end else begin
      // pe_data_valid is a one-cycle pulse per accepted pair; pe_data and
      // pe_weight simply hold between pairs.
      pe_data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            remaining <= cmd_len;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          drain_second <= 1'b0;
          state        <= (remaining != '0) ? S_STREAM : S_DRAIN;
        end
        S_STREAM: begin
          if (op_valid) begin
            pe_data       <= op_data;
            pe_weight     <= op_weight;
            pe_data_valid <= 1'b1;
            remaining     <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // First drain cycle lets the PE absorb the last operand; the
          // accumulator is final during the second.
          if (drain_second) begin
            res_data     <= pe_accum_in;
            drain_second <= 1'b0;
            state        <= S_RESULT;
          end else begin
            drain_second <= 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/neuraedge_pe_driver.md
NEURAEDGE_PE_DRIVER -- requirements
Module: neuraedge_pe_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: activation operand width.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8: weight operand width.
REQ-003 SHALL have parameter ACCUM_WIDTH, default 32: PE accumulator and result width.
REQ-004 SHALL have parameter LEN_WIDTH, default 16: dot-product length field width.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_len  in  LEN_WIDTH  number of operand pairs in the dot product
- op_valid  in  1  operand pair offered
- op_ready  out  1  operand pair accepted when high with op_valid
- op_data  in  DATA_WIDTH  signed activation
- op_weight  in  WEIGHT_WIDTH  signed weight
- pe_enable  out  1  PE multiply enable
- mac_clear  out  1  PE accumulator clear
- accumulate_en  out  1  PE accumulate enable
- pe_data  out  DATA_WIDTH  activation to PE
- pe_weight  out  WEIGHT_WIDTH  weight to PE
- pe_data_valid  out  1  PE operand valid
- pe_accum_in  in  ACCUM_WIDTH  PE accumulator output
- res_valid  out  1  result available
- res_ready  in  1  result consumed when high with res_valid
- res_data  out  ACCUM_WIDTH  captured dot-product result
- busy  out  1  high in any state other than IDLE

Function
REQ-007 SHALL implement FSM states IDLE, CLEAR, STREAM, DRAIN, RESULT.
REQ-008 SHALL drive cmd_ready, op_ready, mac_clear, pe_enable, accumulate_en, res_valid, busy as Moore decodes of the state register only.
REQ-009 IDLE: cmd_ready=1; on cmd_valid, latch cmd_len into a remaining-count register and go to CLEAR.
REQ-010 CLEAR: exactly one cycle, mac_clear=1, pe_enable=1; next state STREAM if latched length>0, else DRAIN.
REQ-011 STREAM: op_ready=1, pe_enable=1, accumulate_en=1; on each op_valid&&op_ready, register op_data/op_weight into pe_data/pe_weight, set pe_data_valid=1 for the next cycle, and decrement the remaining count.
REQ-012 STREAM: a cycle without a handshake SHALL register pe_data_valid=0, leave the count unchanged, and hold pe_data/pe_weight.
REQ-013 The handshake that brings the remaining count from 1 to 0 SHALL move the FSM to DRAIN.
REQ-014 DRAIN: exactly two cycles, pe_enable=1, accumulate_en=1, op_ready=0; at the end of the second cycle, register pe_accum_in into res_data and go to RESULT.
REQ-015 RESULT: res_valid=1 and res_data held stable until res_ready; on res_valid&&res_ready go to IDLE.
REQ-016 Latency SHALL be res_valid high 3 cycles after the last operand handshake, and 4 cycles after the command handshake when cmd_len=0.
REQ-017 SHALL accept no new command before the current result is consumed (cmd_ready=0 outside IDLE).
REQ-018 SHALL ignore op_valid outside STREAM (op_ready=0) and cmd_valid outside IDLE.
REQ-019 cmd_len=0 SHALL yield res_data=0, with mac_clear asserted and no pe_data_valid pulse.
REQ-020 cmd_len SHALL range up to 2^LEN_WIDTH-1 with no count wrap; overflow of the accumulator is owned by the PE (modular) and passed through unchanged.
REQ-021 The driver SHALL do no arithmetic on operands; it passes operand bits unaltered.

Reset
REQ-022 While rst=1: state=IDLE, remaining count=0, pe_data=0, pe_weight=0, pe_data_valid=0, res_data=0.
REQ-023 While rst=1, the state-decoded outputs SHALL follow IDLE: cmd_ready=1 (after first clock edge under reset), all others 0.
REQ-024 Reset mid-operation SHALL abort without emitting res_valid and without asserting mac_clear; the next command's CLEAR reinitialises the PE.

Verification
REQ-025 Reset: hold rst 2 cycles -> all outputs 0 except cmd_ready=1; busy=0.
REQ-026 cmd_len=3, pairs (2,3),(-1,4),(5,5) back-to-back, with a behavioural PE attached -> one mac_clear pulse, three pe_data_valid pulses, res_data=27, res_valid exactly 3 cycles after the third handshake.
REQ-027 cmd_len=0 -> mac_clear for 1 cycle, no pe_data_valid, res_data=0, res_valid 4 cycles after the command handshake.
REQ-028 cmd_len=4, op_valid alternating 1/0, pairs (1,1),(2,2),(3,3),(4,4) -> pe_data_valid only on accepted cycles, res_data=30.
REQ-029 res_ready held 0 for 5 cycles in RESULT -> res_valid and res_data stable, cmd_ready=0; res_ready=1 -> IDLE next cycle.
REQ-030 rst pulsed after 2 of 4 pairs -> IDLE, no res_valid; then cmd_len=1, pair (7,-2) -> res_data=0xFFFFFFF2.
